// File: rtl/tt_sweep_pkg.sv
// Shared types and sizes for the tt_sweep truth-table sweeper.
// Optional mismatch reporting is enabled by defining TT_SWEEP_MISMATCH_EN.
package tt_sweep_pkg;

  localparam int N_VEC      = 16;
  localparam int VEC_W      = 4;
  localparam int TBL_W      = 16;
  localparam int CNT_W      = 4;
  localparam int SETTLE_MAX = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/tt_sweep_if.sv
// Request/response bundle between a sweep requester and tt_sweep.
// mism_valid/mism_idx exist only when TT_SWEEP_MISMATCH_EN is defined.
interface tt_sweep_if;
  import tt_sweep_pkg::*;

  logic             start;
  logic [TBL_W-1:0] expected;
  logic [VEC_W-1:0] abcd;
  logic             f_in;
  logic             busy;
  logic             done;
  logic [TBL_W-1:0] truth_table;
  logic             match;
`ifdef TT_SWEEP_MISMATCH_EN
  logic             mism_valid;
  logic [VEC_W-1:0] mism_idx;
`endif

  modport master (
    output start, expected, f_in,
`ifdef TT_SWEEP_MISMATCH_EN
    input  mism_valid, mism_idx,
`endif
    input  abcd, busy, done, truth_table, match
  );

  modport slave (
    input  start, expected, f_in,
`ifdef TT_SWEEP_MISMATCH_EN
    output mism_valid, mism_idx,
`endif
    output abcd, busy, done, truth_table, match
  );

endinterface

// File: rtl/tt_sweep_prienc.sv
// Lowest-set-bit encoder: idx is the position of the lowest 1 in vec, or 0 if vec is all zero.
// Used by tt_sweep only when TT_SWEEP_MISMATCH_EN is defined.
module tt_sweep_prienc
  import tt_sweep_pkg::*;
(
  input  logic [TBL_W-1:0] vec,
  output logic [VEC_W-1:0] idx
);

  always_comb begin
    // NOTE: assign a default before any conditional write so no latch is inferred.
    idx = '0;
    // Scan downwards so the last hit, the lowest set bit, wins.
    for (int k = TBL_W - 1; k >= 0; k--) begin
      if (vec[k]) idx = VEC_W'(k);
    end
  end

endmodule

// File: rtl/tt_sweep.sv
// Exhaustive 4-input sweeper: drives abcd = 0..15, holds each vector SETTLE cycles,
// captures f_in into truth_table and compares it with the latched expected table.
// Define TT_SWEEP_MISMATCH_EN to add mism_valid/mism_idx.
module tt_sweep
  import tt_sweep_pkg::*;
#(
  parameter int SETTLE = 1  // legal range 1..15
) (
  input  logic        clk,
  input  logic        rst,
  tt_sweep_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
  localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(N_VEC - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [VEC_W-1:0] abcd_q;
  logic [TBL_W-1:0] tbl_q;
  logic [TBL_W-1:0] exp_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;
  logic             match_w;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      abcd_q  <= '0;
      tbl_q   <= '0;
      exp_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch sees pre-edge values.
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state   <= RUN;
            busy_q  <= 1'b1;
            cnt     <= '0;
            abcd_q  <= '0;
            tbl_q   <= '0;
            valid_q <= 1'b0;
            exp_q   <= bus.expected;
          end
        end
        RUN: begin
          if (cnt == CNT_LAST) begin
            // Settle time elapsed: capture this vector's response and step.
            cnt           <= '0;
            tbl_q[abcd_q] <= bus.f_in;
            if (abcd_q == VEC_LAST) begin
              state   <= DONE;
              valid_q <= 1'b1;
              done_q  <= 1'b1;
            end else begin
              abcd_q <= abcd_q + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          abcd_q <= '0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          abcd_q <= '0;
        end
      endcase
    end
  end

  // match is purely a function of registered state, so it holds until the next start.
  assign match_w         = valid_q & (tbl_q == exp_q);

  assign bus.abcd        = abcd_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.truth_table = tbl_q;
  assign bus.match       = match_w;

`ifdef TT_SWEEP_MISMATCH_EN
  logic [VEC_W-1:0] mism_idx_w;

  tt_sweep_prienc u_prienc (
    .vec (tbl_q ^ exp_q),
    .idx (mism_idx_w)
  );

  assign bus.mism_valid = valid_q & ~match_w;
  assign bus.mism_idx   = mism_idx_w;
`endif

endmodule

// File: tb/tb_tt_sweep.sv
// Self-checking bench for tt_sweep: two instances (SETTLE=1 and SETTLE=3) compared every
// cycle against a timeline model, plus directed literal checks and randomized sweeps.
module tb_tt_sweep;
  import tt_sweep_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  start_v = '0;
  logic [15:0] exp_v [2];
  logic [15:0] fut_v [2];   // truth table of the function under test per instance

  tt_sweep_if bus1 ();
  tt_sweep_if bus3 ();

  assign bus1.start    = start_v[0];
  assign bus1.expected = exp_v[0];
  assign bus1.f_in     = fut_v[0][bus1.abcd];
  assign bus3.start    = start_v[1];
  assign bus3.expected = exp_v[1];
  assign bus3.f_in     = fut_v[1][bus3.abcd];

  tt_sweep #(.SETTLE(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  tt_sweep #(.SETTLE(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

  logic [3:0]  abcd_o  [2];
  logic [15:0] table_o [2];
  logic [1:0]  busy_o, done_o, match_o;
  assign abcd_o[0]  = bus1.abcd;        assign abcd_o[1]  = bus3.abcd;
  assign table_o[0] = bus1.truth_table; assign table_o[1] = bus3.truth_table;
  assign busy_o     = {bus3.busy, bus1.busy};
  assign done_o     = {bus3.done, bus1.done};
  assign match_o    = {bus3.match, bus1.match};
`ifdef TT_SWEEP_MISMATCH_EN
  logic [1:0] mv_o;
  logic [3:0] mi_o [2];
  assign mv_o    = {bus3.mism_valid, bus1.mism_valid};
  assign mi_o[0] = bus1.mism_idx;
  assign mi_o[1] = bus3.mism_idx;
`endif

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int settle_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // Timeline model: n_m = edges since the accepted start (-1 when idle).
  // Vector k is on abcd during n in [S*k, S*(k+1)), and is captured once n reaches S*(k+1).
  int          n_m     [2];
  logic [15:0] tbl_m   [2];
  logic [15:0] expl_m  [2];
  logic [15:0] fut_m   [2];
  bit          valid_m [2];
  bit          model_live = 1'b0;

  always @(posedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        n_m[d] = -1; tbl_m[d] = '0; expl_m[d] = '0; valid_m[d] = 1'b0;
      end else if (n_m[d] < 0) begin
        if (start_v[d]) begin
          n_m[d] = 0; tbl_m[d] = '0; valid_m[d] = 1'b0;
          expl_m[d] = exp_v[d]; fut_m[d] = fut_v[d];
        end
      end else begin
        n_m[d]++;
        if (n_m[d] == 16 * settle_of(d)) begin
          tbl_m[d] = fut_m[d]; valid_m[d] = 1'b1;
        end else if (n_m[d] > 16 * settle_of(d)) begin
          n_m[d] = -1;
        end
      end
    end
    if (rst) model_live = 1'b1;
  end

  // NOTE: outputs are compared on the falling edge, well away from the register updates.
  always @(negedge clk) begin
    if (model_live) begin
      for (int d = 0; d < 2; d++) begin
        automatic int          s  = settle_of(d);
        automatic int          n  = n_m[d];
        automatic logic [3:0]  ea = '0;
        automatic bit          eb = 1'b0;
        automatic bit          ed = 1'b0;
        automatic logic [15:0] et = tbl_m[d];
        automatic bit          em;
        if (n >= 0 && n < 16 * s) begin
          ea = 4'(n / s); eb = 1'b1; et = '0;
          for (int k = 0; k < n / s; k++) et[k] = fut_m[d][k];
        end else if (n >= 16 * s) begin
          ea = 4'd15; eb = 1'b1; ed = 1'b1; et = fut_m[d];
        end
        em = valid_m[d] && (et == expl_m[d]);
        check($sformatf("abcd[%0d]", d),  16'(abcd_o[d]), 16'(ea));
        check($sformatf("busy[%0d]", d),  16'(busy_o[d]), 16'(eb));
        check($sformatf("done[%0d]", d),  16'(done_o[d]), 16'(ed));
        check($sformatf("table[%0d]", d), table_o[d], et);
        check($sformatf("match[%0d]", d), 16'(match_o[d]), 16'(em));
`ifdef TT_SWEEP_MISMATCH_EN
        begin
          automatic logic [3:0] ei = '0;
          for (int k = 15; k >= 0; k--) if (et[k] != expl_m[d][k]) ei = 4'(k);
          check($sformatf("mism_valid[%0d]", d), 16'(mv_o[d]), 16'(valid_m[d] && !em));
          check($sformatf("mism_idx[%0d]", d), 16'(mi_o[d]), 16'(ei));
        end
`endif
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(input int d, output int waited);
    waited = 0;
    while (!done_o[d] && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!done_o[d]) check("done_timeout", 16'(done_o[d]), 16'd1);
  endtask

  task automatic wait_idle(input int d);
    for (int i = 0; i < 200 && busy_o[d]; i++) @(negedge clk);
    if (busy_o[d]) check("idle_timeout", 16'(busy_o[d]), 16'd0);
  endtask

  // Starts a sweep from idle; returns edges from the accepting edge to the done cycle.
  task automatic run_sweep(input int d, input logic [15:0] e, input logic [15:0] f, output int lat);
    int t0, w;
    fut_v[d] = f; exp_v[d] = e; start_v[d] = 1'b1;
    @(negedge clk);
    start_v[d] = 1'b0;
    exp_v[d]   = ~e;   // must not disturb the latched copy
    t0 = cyc;
    wait_done(d, w);
    lat = cyc - t0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, ndone, w;
    exp_v[0] = '0; exp_v[1] = '0;
    fut_v[0] = 16'hB1B1; fut_v[1] = 16'hB1B1;

    // Reset held two cycles
    rst = 1'b1;
    tick(2);
    check("rst_abcd",  16'(abcd_o[0]), 16'd0);
    check("rst_busy",  16'(busy_o[0]), 16'd0);
    check("rst_done",  16'(done_o[0]), 16'd0);
    check("rst_table", table_o[0], 16'h0000);
    check("rst_match", 16'(match_o[0]), 16'd0);
    rst = 1'b0;
    tick(2);

    // Matching sweep, SETTLE=1
    run_sweep(0, 16'hB1B1, 16'hB1B1, lat);
    check("s1_latency", 16'(lat), 16'd16);
    check("s1_table", table_o[0], 16'hB1B1);
    check("s1_match", 16'(match_o[0]), 16'd1);
    tick(5);
    check("s1_match_hold", 16'(match_o[0]), 16'd1);

    // Mismatch in bit 0, then in bit 15
    run_sweep(0, 16'hB1B0, 16'hB1B1, lat);
    check("mm0_match", 16'(match_o[0]), 16'd0);
`ifdef TT_SWEEP_MISMATCH_EN
    check("mm0_valid", 16'(mv_o[0]), 16'd1);
    check("mm0_idx", 16'(mi_o[0]), 16'd0);
`endif
    tick(2);
    run_sweep(0, 16'h31B1, 16'hB1B1, lat);
    check("mm15_match", 16'(match_o[0]), 16'd0);
`ifdef TT_SWEEP_MISMATCH_EN
    check("mm15_idx", 16'(mi_o[0]), 16'd15);
`endif
    tick(2);

    // Start pulse mid-sweep is ignored; exactly one done
    fut_v[0] = 16'hB1B1; exp_v[0] = 16'hB1B1; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    for (int i = 0; i < 40 && abcd_o[0] != 4'd5; i++) @(negedge clk);
    check("mid_reach5", 16'(abcd_o[0]), 16'd5);
    start_v[0] = 1'b1;
    ndone = 0;
    @(negedge clk);
    start_v[0] = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (done_o[0]) ndone++;
      @(negedge clk);
    end
    check("mid_done_count", 16'(ndone), 16'd1);

    // Start held high: one IDLE cycle, then a fresh sweep with a cleared table
    start_v[0] = 1'b1;
    wait_done(0, w);
    @(negedge clk);
    check("b2b_idle_busy", 16'(busy_o[0]), 16'd0);
    @(negedge clk);
    check("b2b_restart_busy", 16'(busy_o[0]), 16'd1);
    check("b2b_restart_table", table_o[0], 16'h0000);
    check("b2b_restart_abcd", 16'(abcd_o[0]), 16'd0);
    start_v[0] = 1'b0;
    wait_done(0, w);
    tick(2);

    // Reset mid-sweep aborts without done
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    for (int i = 0; i < 40 && abcd_o[0] != 4'd7; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_abcd", 16'(abcd_o[0]), 16'd0);
    check("abort_busy", 16'(busy_o[0]), 16'd0);
    check("abort_table", table_o[0], 16'h0000);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done_o[0]) ndone++;
      @(negedge clk);
    end
    check("abort_no_done", 16'(ndone), 16'd0);

    // SETTLE=3 instance
    run_sweep(1, 16'hB1B1, 16'hB1B1, lat);
    check("s3_latency", 16'(lat), 16'd48);
    check("s3_table", table_o[1], 16'hB1B1);
    check("s3_match", 16'(match_o[1]), 16'd1);
    tick(3);

    // Randomized sweeps: random functions, expectations, start holds and aborts
    for (int it = 0; it < 40; it++) begin
      automatic int          d    = $urandom_range(0, 1);
      automatic logic [15:0] f    = 16'($urandom);
      automatic logic [15:0] e    = 16'($urandom);
      automatic int          sel  = $urandom_range(0, 3);
      automatic int          hold = ($urandom_range(0, 3) == 0) ? $urandom_range(18, 40) : $urandom_range(1, 3);
      if (sel == 0) e = f;
      else if (sel == 1) e = f ^ (16'h1 << $urandom_range(0, 15));
      fut_v[d] = f; exp_v[d] = e;
      tick($urandom_range(0, 3));
      start_v[d] = 1'b1;
      tick(hold);
      start_v[d] = 1'b0;
      exp_v[d] = 16'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        tick($urandom_range(0, 20));
        rst = 1'b1;
        tick($urandom_range(1, 2));
        rst = 1'b0;
      end
      wait_idle(d);
      tick(2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tt_sweep.md
TT_SWEEP -- requirements
Module: tt_sweep

Interface
REQ-001 SETTLE, 1, cycles each input vector is held before its response is sampled; legal range 1..15.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request one full sweep; sampled only in IDLE.
REQ-005 expected  input  16  expected truth table; bit k is the expected response to vector k; latched on accepted start.
REQ-006 abcd  output  4  stimulus vector to the function under test; a is the MSB, d is the LSB.
REQ-007 f_in  input  1  response of the combinational function under test.
REQ-008 busy  output  1  high in RUN and DONE.
REQ-009 done  output  1  one-cycle pulse at sweep completion.
REQ-010 table  output  16  captured truth table; bit k is f_in sampled for vector k.
REQ-011 match  output  1  high when a completed sweep's table equals the latched expected value.

Function
REQ-012 The FSM SHALL have states IDLE, RUN and DONE: IDLE->RUN on start; RUN->DONE when table[15] is written; DONE->IDLE unconditionally after 1 cycle.
REQ-013 On accepted start (edge E0), the block SHALL clear table, clear the valid flag, latch expected, and set abcd=0.
REQ-014 Each vector k SHALL be driven for exactly SETTLE cycles; f_in SHALL be written to table[k] at edge E(SETTLE*(k+1)), and abcd SHALL advance to k+1 at that same edge.
REQ-015 abcd SHALL hold 15 in DONE and return to 0 on entering IDLE; abcd SHALL never wrap from 15 to 0 while in RUN.
REQ-016 The block SHALL assert done for the single cycle following edge E(16*SETTLE); the total latency from accepted start to done is 16*SETTLE cycles.
REQ-017 The valid flag SHALL be set on entry to DONE; match SHALL equal valid & (table == expected_latched) and SHALL hold until the next accepted start or reset.
REQ-018 start SHALL be ignored in RUN and DONE; a start held high continuously SHALL launch back-to-back sweeps, with one IDLE cycle between them.
REQ-019 Changes on the expected input after start is accepted SHALL NOT affect match.

Reset
REQ-020 On rst, the block SHALL go to IDLE with abcd=0, busy=0, done=0, table=0, match=0, valid=0, and the settle counter at 0.
REQ-021 rst SHALL take priority over start and over any in-progress sweep; a sweep aborted by reset SHALL NOT produce done.

Configuration
REQ-022 With TT_SWEEP_MISMATCH_EN defined, the block SHALL add output mism_valid (1 bit), equal to valid & ~match.
REQ-023 With TT_SWEEP_MISMATCH_EN defined, the block SHALL add output mism_idx (4 bits), the lowest k where table[k] != expected_latched[k], or 0 when there is no mismatch.
REQ-024 Without TT_SWEEP_MISMATCH_EN, the mism_valid and mism_idx ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-025 Package tt_sweep_pkg SHALL hold the state enum (IDLE/RUN/DONE), N_VEC=16, VEC_W=4, and TBL_W=16.
REQ-026 The mismatch index SHALL come from sub-module tt_sweep_prienc (16-bit lowest-set-bit encoder on table ^ expected_latched), instantiated only under the macro.

Verification (the bench models f_in = (b&d)|(~c&~d), whose truth table is 16'hB1B1)
REQ-027 Reset then idle: rst held 2 cycles -> abcd=0, busy=0, done=0, table=0, match=0.
REQ-028 SETTLE=1, expected=16'hB1B1, 1-cycle start pulse -> abcd steps 0..15 one per cycle, done pulses 16 cycles after the start edge, table=16'hB1B1, match=1 until the next start.
REQ-029 SETTLE=1, expected=16'hB1B0 -> match=0; with the macro, mism_valid=1 and mism_idx=0. With expected=16'h31B1 -> mism_idx=15.
REQ-030 start pulsed at abcd=5 mid-sweep -> ignored, with a single done; start held high -> second sweep begins 1 IDLE cycle after done, and table reads 0 at that sweep's start.
REQ-031 rst asserted while abcd=7 -> after the next edge abcd=0, busy=0, table=0, and done never pulses.
REQ-032 SETTLE=3 -> each vector is held 3 cycles, done pulses 48 cycles after the start edge, and table=16'hB1B1.
